apb_cmd_master: RTL and testbench

- APB requester (initiator) that turns a simple valid/ready command stream into single APB transfers toward our APB register slaves, e.g. the clock-counter block.
- Drives SETUP/ACCESS phases, waits on p_ready, captures p_rdata/p_slverr, and returns one response per command.
- Adds alignment checking and an ACCESS-phase timeout so a hung slave cannot stall the requester.

---
 rtl/apb_pkg.sv | 34 +++
 rtl/apb_wait_timer.sv | 38 +++
 rtl/apb_cmd_master.sv | 174 +++++++++++++++++
 tb/tb_apb_cmd_master.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB command requester: FSM state encoding and the
// response payload carried from the ACCESS phase to the response port.
package apb_pkg;

   localparam int unsigned APB_ADDR_W = 32;
   localparam int unsigned APB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   typedef struct packed {
      logic [APB_DATA_W-1:0] rdata;
      logic                  err;
      logic                  timeout;
   } apb_rsp_t;

   // Error response with no data; cause flagged as timeout or not.
   function automatic apb_rsp_t rsp_error(input logic is_timeout);
      apb_rsp_t r;
      r.rdata   = '0;
      r.err     = 1'b1;
      r.timeout = is_timeout;
      return r;
   endfunction

   function automatic logic word_aligned(input logic [1:0] addr_lsb);
      return (addr_lsb == 2'b00);
   endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states; expired flags the last allowed wait cycle.
module apb_wait_timer #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired_c
);

   localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic             w_sat;

   assign w_sat = &r_cnt;

   // Saturating so a disabled timeout never wraps into a false match.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !w_sat) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   generate
      if (TIMEOUT == 0) begin : g_no_timeout
         assign o_expired_c = 1'b0;
      end else begin : g_timeout
         assign o_expired_c = (r_cnt == CNT_W'(TIMEOUT - 1));
      end
   endgenerate

endmodule

// File: rtl/apb_cmd_master.sv
// APB requester: one valid/ready command becomes one SETUP/ACCESS transfer and
// one response, with alignment check and bounded ACCESS wait.
module apb_cmd_master
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W  = APB_ADDR_W,
   parameter int unsigned DATA_W  = APB_DATA_W,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              p_clk,
   input  logic              p_rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic [ADDR_W-1:0] p_addr,
   output logic              p_sel,
   output logic              p_en,
   output logic              p_write,
   output logic [DATA_W-1:0] p_wrdata,
   input  logic              p_ready,
   input  logic [DATA_W-1:0] p_rdata,
   input  logic              p_slverr
);

   apb_state_e        r_state;
   logic [ADDR_W-1:0] r_p_addr;
   logic              r_p_sel;
   logic              r_p_en;
   logic              r_p_write;
   logic [DATA_W-1:0] r_p_wrdata;
   apb_rsp_t          r_rsp;
   logic              r_rsp_valid;

   apb_state_e        w_state_nxt;
   logic [ADDR_W-1:0] w_p_addr_nxt;
   logic              w_p_sel_nxt;
   logic              w_p_en_nxt;
   logic              w_p_write_nxt;
   logic [DATA_W-1:0] w_p_wrdata_nxt;
   apb_rsp_t          w_rsp_nxt;
   logic              w_rsp_valid_nxt;

   logic              w_accept;
   logic              w_aligned;
   logic              w_start;
   logic              w_wait;
   logic              w_expired;

   assign cmd_ready = (r_state == IDLE) && !p_rst;
   assign w_accept  = cmd_valid && cmd_ready;
   assign w_aligned = word_aligned(cmd_addr[1:0]);
   assign w_start   = w_accept && w_aligned;
   assign w_wait    = (r_state == ACCESS) && !p_ready;

   apb_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .i_clk       (p_clk),
      .i_rst       (p_rst),
      .i_clr       (w_start),
      .i_en        (w_wait),
      .o_expired_c (w_expired)
   );

   // Next-state and next-output decode.
   always_comb begin
      w_state_nxt     = r_state;
      w_p_addr_nxt    = r_p_addr;
      w_p_sel_nxt     = r_p_sel;
      w_p_en_nxt      = r_p_en;
      w_p_write_nxt   = r_p_write;
      w_p_wrdata_nxt  = r_p_wrdata;
      w_rsp_nxt       = r_rsp;
      w_rsp_valid_nxt = r_rsp_valid;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_aligned) begin
                  w_p_addr_nxt   = cmd_addr;
                  w_p_write_nxt  = cmd_write;
                  w_p_wrdata_nxt = cmd_write ? cmd_wdata : '0;
                  w_p_sel_nxt    = 1'b1;
                  w_p_en_nxt     = 1'b0;
                  w_state_nxt    = SETUP;
               end else begin
                  w_rsp_nxt       = rsp_error(1'b0);
                  w_rsp_valid_nxt = 1'b1;
                  w_state_nxt     = RESP;
               end
            end
         end

         SETUP: begin
            w_p_en_nxt  = 1'b1;
            w_state_nxt = ACCESS;
         end

         ACCESS: begin
            // A ready slave wins over a timeout firing in the same cycle.
            if (p_ready) begin
               w_rsp_nxt.rdata   = (r_p_write || p_slverr) ? '0 : APB_DATA_W'(p_rdata);
               w_rsp_nxt.err     = p_slverr;
               w_rsp_nxt.timeout = 1'b0;
               w_p_sel_nxt       = 1'b0;
               w_p_en_nxt        = 1'b0;
               w_rsp_valid_nxt   = 1'b1;
               w_state_nxt       = RESP;
            end else if (w_expired) begin
               w_rsp_nxt       = rsp_error(1'b1);
               w_p_sel_nxt     = 1'b0;
               w_p_en_nxt      = 1'b0;
               w_rsp_valid_nxt = 1'b1;
               w_state_nxt     = RESP;
            end
         end

         RESP: begin
            if (rsp_ready) begin
               w_rsp_valid_nxt = 1'b0;
               w_state_nxt     = IDLE;
            end
         end

         default: begin
            w_p_sel_nxt     = 1'b0;
            w_p_en_nxt      = 1'b0;
            w_rsp_valid_nxt = 1'b0;
            w_state_nxt     = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge p_clk) begin
      if (p_rst) begin
         r_state     <= IDLE;
         r_p_addr    <= '0;
         r_p_sel     <= 1'b0;
         r_p_en      <= 1'b0;
         r_p_write   <= 1'b0;
         r_p_wrdata  <= '0;
         r_rsp       <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_p_addr    <= w_p_addr_nxt;
         r_p_sel     <= w_p_sel_nxt;
         r_p_en      <= w_p_en_nxt;
         r_p_write   <= w_p_write_nxt;
         r_p_wrdata  <= w_p_wrdata_nxt;
         r_rsp       <= w_rsp_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
      end
   end

   assign p_addr      = r_p_addr;
   assign p_sel       = r_p_sel;
   assign p_en        = r_p_en;
   assign p_write     = r_p_write;
   assign p_wrdata    = r_p_wrdata;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = DATA_W'(r_rsp.rdata);
   assign rsp_err     = r_rsp.err;
   assign rsp_timeout = r_rsp.timeout;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed table, reset corner cases,
// then randomized commands checked against a transaction-level model.
module tb_apb_cmd_master;

   localparam int unsigned TO = 16;

   logic        p_clk = 1'b0;
   logic        p_rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err, rsp_timeout;
   logic [31:0] p_addr;
   logic        p_sel, p_en, p_write;
   logic [31:0] p_wrdata;
   logic        p_ready;
   logic [31:0] p_rdata;
   logic        p_slverr;

   apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .p_clk(p_clk), .p_rst(p_rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .p_addr(p_addr), .p_sel(p_sel), .p_en(p_en), .p_write(p_write),
      .p_wrdata(p_wrdata), .p_ready(p_ready), .p_rdata(p_rdata), .p_slverr(p_slverr)
   );

   always #5 p_clk = ~p_clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] rdata;
      bit          slverr;
      int          stall;
      bit          e_err;
      bit          e_to;
      logic [31:0] e_rdata;
      int          e_en;
      int          e_lat;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge p_clk);
      #1;
   endtask

   function automatic vec_t mk(bit wr, logic [31:0] addr, logic [31:0] wdata, int waits,
                               logic [31:0] rdata, bit slverr, int stall, bit e_err, bit e_to,
                               logic [31:0] e_rdata, int e_en, int e_lat);
      vec_t v;
      v.wr = wr; v.addr = addr; v.wdata = wdata; v.waits = waits; v.rdata = rdata;
      v.slverr = slverr; v.stall = stall; v.e_err = e_err; v.e_to = e_to;
      v.e_rdata = e_rdata; v.e_en = e_en; v.e_lat = e_lat;
      return v;
   endfunction

   // Transaction-level expectation derived from the protocol rules.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      if (v.addr[1:0] != 2'b00) begin
         r.e_err = 1; r.e_to = 0; r.e_rdata = 0; r.e_en = 0; r.e_lat = 1;
      end else if (TO != 0 && v.waits >= int'(TO)) begin
         r.e_err = 1; r.e_to = 1; r.e_rdata = 0; r.e_en = int'(TO); r.e_lat = 2 + int'(TO);
      end else begin
         r.e_err = v.slverr; r.e_to = 0;
         r.e_rdata = (v.wr || v.slverr) ? 32'h0 : v.rdata;
         r.e_en = v.waits + 1; r.e_lat = 2 + r.e_en;
      end
      return r;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_p_sel"}, 64'(p_sel), 64'(0));
      check({tag, "_p_en"}, 64'(p_en), 64'(0));
      check({tag, "_p_write"}, 64'(p_write), 64'(0));
      check({tag, "_p_addr"}, 64'(p_addr), 64'(0));
      check({tag, "_p_wrdata"}, 64'(p_wrdata), 64'(0));
      check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
      check({tag, "_rsp_flags"}, 64'({rsp_err, rsp_timeout}), 64'(0));
      check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
   endtask

   // Issue one command, act as the APB slave, collect and check the response.
   task automatic run_cmd(input vec_t v, input string tag);
      int          cyc = 1, lat = -1, en_cnt = 0, sel_cnt = 0, exp_sel;
      bit          seen = 0, phase_ok = 1, busy_ok = 1, hold_ok = 1;
      logic [31:0] g_rdata = 0;
      bit          g_err = 0, g_to = 0;
      logic [31:0] exp_wd = v.wr ? v.wdata : 32'h0;

      exp_sel = (v.addr[1:0] == 2'b00) ? v.e_en + 1 : 0;
      cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
      check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
      tick();
      for (int k = 0; k < 200 && !seen; k++) begin
         cmd_valid = 1'($urandom); cmd_addr = $urandom; cmd_write = 1'($urandom);
         if (cmd_ready) busy_ok = 0;
         if (p_en && !p_sel) phase_ok = 0;
         if (p_sel) begin
            sel_cnt++;
            if (p_addr !== v.addr || p_write !== v.wr || p_wrdata !== exp_wd) phase_ok = 0;
         end
         if (rsp_valid) begin
            seen = 1; lat = cyc;
            g_rdata = rsp_rdata; g_err = rsp_err; g_to = rsp_timeout;
         end else begin
            if (p_sel && p_en) begin
               en_cnt++;
               if (en_cnt > v.waits) begin
                  p_ready = 1; p_rdata = v.rdata; p_slverr = v.slverr;
               end else begin
                  p_ready = 0; p_rdata = $urandom; p_slverr = 1'($urandom);
               end
            end else begin
               p_ready = 1'($urandom); p_rdata = $urandom; p_slverr = 1'($urandom);
            end
            tick();
            cyc++;
         end
      end
      check({tag, "_rsp_seen"}, 64'(seen), 64'(1));
      check({tag, "_latency"}, 64'(lat), 64'(v.e_lat));
      check({tag, "_sel_cycles"}, 64'(sel_cnt), 64'(exp_sel));
      check({tag, "_en_cycles"}, 64'(en_cnt), 64'(v.e_en));
      check({tag, "_rsp_err"}, 64'(g_err), 64'(v.e_err));
      check({tag, "_rsp_timeout"}, 64'(g_to), 64'(v.e_to));
      check({tag, "_rsp_rdata"}, 64'(g_rdata), 64'(v.e_rdata));
      check({tag, "_phase_ok"}, 64'(phase_ok), 64'(1));
      check({tag, "_busy_ready"}, 64'(busy_ok), 64'(1));

      rsp_ready = 0;
      for (int s = 0; s < v.stall; s++) begin
         tick();
         cmd_valid = 1'($urandom); cmd_addr = $urandom;
         p_ready = 1'($urandom); p_rdata = $urandom; p_slverr = 1'($urandom);
         if (!rsp_valid || rsp_rdata !== g_rdata || rsp_err !== g_err ||
             rsp_timeout !== g_to || p_sel || cmd_ready) hold_ok = 0;
      end
      if (v.stall > 0) check({tag, "_rsp_hold"}, 64'(hold_ok), 64'(1));
      rsp_ready = 1;
      tick();
      rsp_ready = 0; cmd_valid = 0;
      check({tag, "_rsp_cleared"}, 64'(rsp_valid), 64'(0));
      check({tag, "_back_idle"}, 64'(cmd_ready), 64'(1));
   endtask

   initial begin
      vec_t v;
      bit   hold_ok;
      bit   got;
      logic [31:0] held;

      p_rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
      rsp_ready = 0; p_ready = 0; p_rdata = 0; p_slverr = 0;
      tick(); tick();
      check_reset_outputs("reset");
      check("reset_cmd_ready_in_rst", 64'(cmd_ready), 64'(0));
      p_rst = 0;
      #1;
      check("reset_cmd_ready_after", 64'(cmd_ready), 64'(1));

      // wr, addr, wdata, waits, rdata, slverr, stall | err, to, rdata, en, lat
      tbl[0] = mk(1, 32'h0,   32'h1,    0,    32'h0,        0, 0, 0, 0, 32'h0,        1,  3);
      tbl[1] = mk(0, 32'h8,   32'h0,    3,    32'hDEADBEEF, 0, 1, 0, 0, 32'hDEADBEEF, 4,  6);
      tbl[2] = mk(0, 32'h4,   32'h0,    0,    32'h12345678, 1, 0, 1, 0, 32'h0,        1,  3);
      tbl[3] = mk(0, 32'h10,  32'h0,    1000, 32'h0,        0, 0, 1, 1, 32'h0,        16, 18);
      tbl[4] = mk(1, 32'h6,   32'hAB,   0,    32'h0,        0, 0, 1, 0, 32'h0,        0,  1);
      tbl[5] = mk(0, 32'h20,  32'h0,    15,   32'hA5A5A5A5, 0, 0, 0, 0, 32'hA5A5A5A5, 16, 18);
      tbl[6] = mk(1, 32'hC,   32'hCAFE, 2,    32'hFFFF,     1, 5, 1, 0, 32'h0,        3,  5);
      tbl[7] = mk(0, 32'h3,   32'h0,    0,    32'h77,       0, 2, 1, 0, 32'h0,        0,  1);
      tbl[8] = mk(1, 32'h100, 32'h1234, 16,   32'h0,        0, 0, 1, 1, 32'h0,        16, 18);
      tbl[9] = mk(0, 32'h104, 32'h0,    0,    32'h0F0F,     0, 3, 0, 0, 32'h0F0F,     1,  3);
      for (int i = 0; i < 10; i++) run_cmd(tbl[i], $sformatf("vec%0d", i));

      // Pending response discarded by reset after a 5-cycle stall.
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h40; cmd_wdata = 0;
      tick();
      cmd_valid = 0; p_ready = 1; p_rdata = 32'h55AA_0001; p_slverr = 0;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         if (rsp_valid) got = 1; else tick();
      end
      check("seqA_rsp_seen", 64'(got), 64'(1));
      check("seqA_rdata", 64'(rsp_rdata), 64'(32'h55AA_0001));
      held = rsp_rdata; hold_ok = 1;
      for (int s = 0; s < 5; s++) begin
         tick();
         p_rdata = $urandom;
         if (!rsp_valid || rsp_rdata !== held || rsp_err) hold_ok = 0;
      end
      check("seqA_hold", 64'(hold_ok), 64'(1));
      p_rst = 1;
      tick();
      check_reset_outputs("seqA_rst");
      p_rst = 0;
      #1;
      check("seqA_cmd_ready", 64'(cmd_ready), 64'(1));

      // Reset in the middle of a stretched ACCESS phase.
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h44; cmd_wdata = 32'h9999;
      tick();
      cmd_valid = 0; p_ready = 0;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         if (p_en) got = 1; else tick();
      end
      check("seqB_access", 64'(got), 64'(1));
      tick(); tick();
      check("seqB_still_access", 64'({p_sel, p_en}), 64'(2'b11));
      p_rst = 1;
      tick();
      check_reset_outputs("seqB_rst");
      p_rst = 0;
      #1;
      check("seqB_cmd_ready", 64'(cmd_ready), 64'(1));
      tick();
      check("seqB_quiet", 64'({p_sel, p_en, rsp_valid}), 64'(0));

      // Randomized commands against the transaction model.
      for (int i = 0; i < 40; i++) begin
         int pick;
         v.wr = 1'($urandom);
         v.addr = $urandom;
         if ($urandom_range(0, 3) != 0) v.addr[1:0] = 2'b00;
         v.wdata = $urandom;
         pick = int'($urandom_range(0, 9));
         v.waits = (pick < 5) ? pick : (pick == 5) ? 14 : (pick == 6) ? 15 : (pick == 7) ? 16 : 25;
         v.rdata = $urandom;
         v.slverr = ($urandom_range(0, 3) == 0);
         v.stall = int'($urandom_range(0, 3));
         v = model(v);
         run_cmd(v, $sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
